// File: rtl/ex_mem_stage_if.sv
// EX/MEM stage bus: decoded ID/EX slot going in, EX/MEM pipeline register and
// PC-redirect request coming out. The "slave" side is the stage itself.
interface ex_mem_if;
  // ID/EX slot and pipeline control
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [2:0]  alu_control;
  logic        jr_control;
  logic        branch;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] imm;
  logic        alu_src;
  logic [31:0] pc_plus4;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [4:0]  dest_reg;

  // EX/MEM register and redirect request
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] store_data;
  logic [4:0]  dest_reg_q;
  logic        reg_write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        mem_to_reg_q;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        squashing;

  modport master (
    output in_valid, stall, flush, alu_control, jr_control, branch,
           read_data1, read_data2, imm, alu_src, pc_plus4,
           reg_write, mem_read, mem_write, mem_to_reg, dest_reg,
    input  out_valid, alu_result, zero, store_data, dest_reg_q,
           reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q,
           redirect, redirect_pc, squashing
  );

  modport slave (
    input  in_valid, stall, flush, alu_control, jr_control, branch,
           read_data1, read_data2, imm, alu_src, pc_plus4,
           reg_write, mem_read, mem_write, mem_to_reg, dest_reg,
    output out_valid, alu_result, zero, store_data, dest_reg_q,
           reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q,
           redirect, redirect_pc, squashing
  );
endinterface

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: ALU, jr/beq resolution and a
// RUN/SQUASH machine that turns the instruction after a redirect into a bubble.
module ex_mem_stage (
  input  logic     clk,
  input  logic     rst_n,
  ex_mem_if.slave  bus
);

  typedef enum logic {RUN, SQUASH} state_t;

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [31:0] alu_q, alu_d;
  logic        zero_q, zero_d;
  logic [31:0] store_q, store_d;
  logic [4:0]  dest_q, dest_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] alu_res;
  logic        is_flow;
  logic        take_redirect;
  logic [31:0] branch_target;

  // ALU and control-flow resolution
  always_comb begin
    op_a = bus.read_data1;
    op_b = bus.alu_src ? bus.imm : bus.read_data2;
    alu_res = '0;
    case (bus.alu_control)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a & op_b;
      3'b011:  alu_res = op_a | op_b;
      3'b100:  alu_res = {31'd0, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
    is_flow       = bus.jr_control | bus.branch;
    // beq is taken when A-B would be zero, independent of which ALU op was decoded
    take_redirect = bus.jr_control | (bus.branch & (op_a == op_b));
    branch_target = bus.pc_plus4 + {bus.imm[29:0], 2'b00};
  end

  // Next-state and next-register values; everything holds by default (stall)
  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    alu_d         = alu_q;
    zero_d        = zero_q;
    store_d       = store_q;
    dest_d        = dest_q;
    reg_write_d   = reg_write_q;
    mem_read_d    = mem_read_q;
    mem_write_d   = mem_write_q;
    mem_to_reg_d  = mem_to_reg_q;
    redirect_d    = redirect_q;
    redirect_pc_d = redirect_pc_q;

    if (bus.flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      redirect_d   = 1'b0;
      state_d      = RUN;
    end else if (!bus.stall) begin
      alu_d      = alu_res;
      zero_d     = (alu_res == 32'd0);
      store_d    = bus.read_data2;
      dest_d     = bus.dest_reg;
      redirect_d = 1'b0;
      if (!bus.in_valid || state_q == SQUASH) begin
        // Bubble: either nothing arrived, or this is the wrong-path instruction
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = 1'b0;
        if (bus.in_valid) begin
          state_d = RUN;
        end
      end else begin
        valid_d      = 1'b1;
        reg_write_d  = bus.reg_write  & ~is_flow;
        mem_read_d   = bus.mem_read   & ~is_flow;
        mem_write_d  = bus.mem_write  & ~is_flow;
        mem_to_reg_d = bus.mem_to_reg & ~is_flow;
        if (take_redirect) begin
          redirect_d    = 1'b1;
          redirect_pc_d = bus.jr_control ? op_a : branch_target;
          state_d       = SQUASH;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      valid_q       <= 1'b0;
      alu_q         <= '0;
      zero_q        <= 1'b0;
      store_q       <= '0;
      dest_q        <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      alu_q         <= alu_d;
      zero_q        <= zero_d;
      store_q       <= store_d;
      dest_q        <= dest_d;
      reg_write_q   <= reg_write_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_to_reg_q  <= mem_to_reg_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.out_valid    = valid_q;
  assign bus.alu_result   = alu_q;
  assign bus.zero         = zero_q;
  assign bus.store_data   = store_q;
  assign bus.dest_reg_q   = dest_q;
  assign bus.reg_write_q  = reg_write_q;
  assign bus.mem_read_q   = mem_read_q;
  assign bus.mem_write_q  = mem_write_q;
  assign bus.mem_to_reg_q = mem_to_reg_q;
  assign bus.redirect     = redirect_q;
  assign bus.redirect_pc  = redirect_pc_q;
  assign bus.squashing    = (state_q == SQUASH);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: ALU vector table, hand-written redirect/stall/flush/reset
// sequences, then random traffic checked against a behavioural model.
module tb_ex_mem_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ex_mem_if bus();

  ex_mem_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit        valid;
    bit [31:0] alu;
    bit        zero;
    bit [31:0] store;
    bit [4:0]  dest;
    bit        rw, mr, mw, mtr;
    bit        redir;
    bit [31:0] rpc;
    bit        care;   // data fields meaningful (not a bubble)
  } exp_t;

  exp_t e;
  bit   squash_pending;

  function automatic bit [31:0] ref_alu(bit [2:0] c, bit [31:0] a, bit [31:0] b);
    case (c)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic make_bubble();
    e.valid = 0; e.rw = 0; e.mr = 0; e.mw = 0; e.mtr = 0; e.redir = 0; e.care = 0;
  endtask

  task automatic model_edge();
    bit [31:0] b;
    bit        flow;
    if (!rst_n) begin
      e = '{default: '0};
      e.care = 1;
      squash_pending = 0;
    end else if (bus.flush) begin
      make_bubble();
      squash_pending = 0;
    end else if (!bus.stall) begin
      b = bus.alu_src ? bus.imm : bus.read_data2;
      if (!bus.in_valid) begin
        make_bubble();
      end else if (squash_pending) begin
        make_bubble();
        squash_pending = 0;
      end else begin
        flow    = bus.jr_control || bus.branch;
        e.valid = 1;
        e.care  = 1;
        e.alu   = ref_alu(bus.alu_control, bus.read_data1, b);
        e.zero  = (e.alu == 0);
        e.store = bus.read_data2;
        e.dest  = bus.dest_reg;
        e.rw    = bus.reg_write  && !flow;
        e.mr    = bus.mem_read   && !flow;
        e.mw    = bus.mem_write  && !flow;
        e.mtr   = bus.mem_to_reg && !flow;
        e.redir = 0;
        if (bus.jr_control) begin
          e.redir = 1; e.rpc = bus.read_data1; squash_pending = 1;
        end else if (bus.branch && (bus.read_data1 - b) == 0) begin
          e.redir = 1; e.rpc = bus.pc_plus4 + bus.imm * 4; squash_pending = 1;
        end
      end
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".out_valid"},    bus.out_valid,    e.valid);
    chk({tag, ".squashing"},    bus.squashing,    squash_pending);
    chk({tag, ".redirect"},     bus.redirect,     e.redir);
    chk({tag, ".reg_write_q"},  bus.reg_write_q,  e.rw);
    chk({tag, ".mem_read_q"},   bus.mem_read_q,   e.mr);
    chk({tag, ".mem_write_q"},  bus.mem_write_q,  e.mw);
    chk({tag, ".mem_to_reg_q"}, bus.mem_to_reg_q, e.mtr);
    if (e.care) begin
      chk({tag, ".alu_result"}, bus.alu_result, e.alu);
      chk({tag, ".zero"},       bus.zero,       e.zero);
      chk({tag, ".store_data"}, bus.store_data, e.store);
      chk({tag, ".dest_reg_q"}, bus.dest_reg_q, e.dest);
    end
    if (e.redir) chk({tag, ".redirect_pc"}, bus.redirect_pc, e.rpc);
  endtask

  // One clock: DUT and model capture the same inputs, outputs checked #1 later
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  task automatic drive(input bit v, input bit [2:0] c, input bit [31:0] a,
                       input bit [31:0] b, input bit src, input bit [31:0] im,
                       input bit jr, input bit br, input bit [31:0] pc4);
    bus.in_valid    = v;
    bus.alu_control = c;
    bus.read_data1  = a;
    bus.read_data2  = b;
    bus.alu_src     = src;
    bus.imm         = im;
    bus.jr_control  = jr;
    bus.branch      = br;
    bus.pc_plus4    = pc4;
    bus.reg_write   = 1;
    bus.mem_read    = 1;
    bus.mem_write   = 0;
    bus.mem_to_reg  = 1;
    bus.dest_reg    = 5'd9;
  endtask

  task automatic idle();
    drive(0, 3'd0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- ALU vector table ----------------
  typedef struct {
    bit [2:0]  code;
    bit [31:0] a, b;
    bit        src;
    bit [31:0] im;
    bit [31:0] exp_res;
    bit        exp_zero;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{3'd0, 32'h7FFFFFFF, 32'd1,        0, 32'd0,        32'h80000000, 0};
    vecs[1] = '{3'd4, 32'hFFFFFFFF, 32'd0,        0, 32'd0,        32'd1,        0};
    vecs[2] = '{3'd4, 32'd0,        32'hFFFFFFFF, 0, 32'd0,        32'd0,        1};
    vecs[3] = '{3'd1, 32'h1234,     32'h1234,     0, 32'd0,        32'd0,        1};
    vecs[4] = '{3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 0, 32'd0,        32'hF000F000, 0};
    vecs[5] = '{3'd3, 32'h0F0F0000, 32'h000000F0, 0, 32'd0,        32'h0F0F00F0, 0};
    vecs[6] = '{3'd5, 32'd5,        32'd7,        0, 32'd0,        32'd0,        1};
    vecs[7] = '{3'd7, 32'hFFFF,     32'h1,        0, 32'd0,        32'd0,        1};
    vecs[8] = '{3'd0, 32'd10,       32'd99,       1, 32'hFFFFFFFE, 32'd8,        0};
    vecs[9] = '{3'd1, 32'd0,        32'd1,        0, 32'd0,        32'hFFFFFFFF, 0};

    e = '{default: '0};
    squash_pending = 0;
    rst_n = 0;
    bus.stall = 0;
    bus.flush = 0;
    idle();

    // Reset state
    step("reset0");
    step("reset1");
    chk("reset.alu_result", bus.alu_result, 32'd0);
    chk("reset.redirect_pc", bus.redirect_pc, 32'd0);
    rst_n = 1;

    foreach (vecs[i]) begin
      drive(1, vecs[i].code, vecs[i].a, vecs[i].b, vecs[i].src, vecs[i].im, 0, 0, 0);
      step("vec");
      chk($sformatf("vec%0d.result", i), bus.alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d.zero", i),   bus.zero,       vecs[i].exp_zero);
      chk($sformatf("vec%0d.valid", i),  bus.out_valid,  1);
    end

    // jr: redirect once, next valid squashed, following one passes
    drive(1, 3'd0, 32'h00400020, 0, 0, 0, 1, 0, 32'h44);
    step("jr");
    chk("jr.redirect", bus.redirect, 1);
    chk("jr.redirect_pc", bus.redirect_pc, 32'h00400020);
    chk("jr.reg_write_q", bus.reg_write_q, 0);
    idle();
    step("jr_idle");
    chk("jr_idle.redirect", bus.redirect, 0);
    chk("jr_idle.squashing", bus.squashing, 1);
    drive(1, 3'd0, 1, 2, 0, 0, 0, 0, 0);
    step("jr_sq");
    chk("jr_sq.out_valid", bus.out_valid, 0);
    step("jr_next");
    chk("jr_next.out_valid", bus.out_valid, 1);

    // beq taken / not taken
    drive(1, 3'd1, 5, 5, 0, 32'hFFFFFFFF, 0, 1, 32'h100);
    step("beq_t");
    chk("beq_t.redirect", bus.redirect, 1);
    chk("beq_t.redirect_pc", bus.redirect_pc, 32'h0FC);
    drive(1, 3'd0, 3, 4, 0, 0, 0, 0, 0);
    step("beq_sq");
    drive(1, 3'd1, 5, 6, 0, 32'hFFFFFFFF, 0, 1, 32'h100);
    step("beq_nt");
    chk("beq_nt.redirect", bus.redirect, 0);
    chk("beq_nt.squashing", bus.squashing, 0);

    // Stall holds a pending redirect, then flush under stall clears it
    drive(1, 3'd0, 32'h00400020, 0, 0, 0, 1, 0, 0);
    step("stl_jr");
    bus.stall = 1;
    drive(1, 3'd0, 7, 8, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step("stall");
      chk("stall.redirect", bus.redirect, 1);
      chk("stall.redirect_pc", bus.redirect_pc, 32'h00400020);
    end
    bus.flush = 1;
    step("flush");
    chk("flush.out_valid", bus.out_valid, 0);
    chk("flush.redirect", bus.redirect, 0);
    chk("flush.squashing", bus.squashing, 0);
    bus.stall = 0;

    // Redirect coinciding with flush resolves as flush
    drive(1, 3'd0, 32'h1000, 0, 0, 0, 1, 0, 0);
    step("jr_flush");
    chk("jr_flush.redirect", bus.redirect, 0);
    bus.flush = 0;

    // Reset while in SQUASH
    drive(1, 3'd0, 32'h2000, 0, 0, 0, 1, 0, 0);
    step("rs_jr");
    idle();
    step("rs_idle");
    rst_n = 0;
    step("rs_reset");
    chk("rs_reset.squashing", bus.squashing, 0);
    chk("rs_reset.redirect", bus.redirect, 0);
    chk("rs_reset.alu_result", bus.alu_result, 0);
    rst_n = 1;
    drive(1, 3'd0, 20, 22, 0, 0, 0, 0, 0);
    step("rs_add");
    chk("rs_add.out_valid", bus.out_valid, 1);
    chk("rs_add.alu_result", bus.alu_result, 42);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      int kind;
      rst_n     = ($urandom_range(0, 59) != 0);
      bus.stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 19) == 0);
      kind = $urandom_range(0, 9);
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.read_data1  = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
      bus.read_data2  = ($urandom_range(0, 1) != 0) ? bus.read_data1 : $urandom;
      bus.imm         = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 15);
      bus.pc_plus4    = $urandom;
      bus.reg_write   = 1'($urandom);
      bus.mem_read    = 1'($urandom);
      bus.mem_write   = 1'($urandom);
      bus.mem_to_reg  = 1'($urandom);
      bus.dest_reg    = 5'($urandom);
      bus.jr_control  = (kind == 0);
      bus.branch      = (kind == 1 || kind == 2);
      bus.alu_control = bus.branch ? 3'd1 : 3'($urandom);
      bus.alu_src     = bus.branch ? 1'b0 : 1'($urandom);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have exactly one clock and a synchronous, active-low reset, listed first: clk input 1 (rising-edge clock); rst_n input 1 (synchronous, active-low reset).
REQ-002 SHALL have ports: in_valid in 1 (ID/EX slot holds an instruction); stall in 1 (hold EX/MEM register); flush in 1 (turn next capture into bubble).
REQ-003 SHALL have ports: alu_control in 3 (000 add, 001 sub, 010 and, 011 or, 100 slt); jr_control in 1 (instruction is jr); branch in 1 (instruction is beq).
REQ-004 SHALL have ports: read_data1 in 32; read_data2 in 32; imm in 32 (sign-extended immediate); alu_src in 1 (1 selects imm as operand B); pc_plus4 in 32.
REQ-005 SHALL have ports: reg_write, mem_read, mem_write, mem_to_reg in 1 each; dest_reg in 5.
REQ-006 SHALL have outputs: out_valid 1; alu_result 32; zero 1; store_data 32; dest_reg_q 5; reg_write_q, mem_read_q, mem_write_q, mem_to_reg_q 1 each.
REQ-007 SHALL have outputs: redirect 1 (one-cycle PC redirect pulse); redirect_pc 32 (target PC); squashing 1 (high while state = SQUASH).

Function
REQ-008 Operand A SHALL be read_data1; operand B SHALL be imm when alu_src=1, else read_data2.
REQ-009 add/sub SHALL wrap modulo 2^32 with no overflow flag; and/or SHALL be bitwise; slt SHALL yield 32'd1 if A<B as signed, else 0; codes 101-111 SHALL yield 0.
REQ-010 zero SHALL be registered as (alu_result == 0), computed from the same cycle's ALU output.
REQ-011 Capture: on a rising edge with rst_n=1 and stall=0, the EX/MEM register SHALL load the ALU result, read_data2 (as store_data), dest_reg, control bits and out_valid=in_valid; latency from in_valid to out_valid SHALL be exactly 1 cycle.
REQ-012 stall=1 with flush=0 SHALL hold every registered output, including redirect, redirect_pc and state.
REQ-013 flush=1 SHALL override stall and load a bubble: out_valid=0, all *_q control bits=0, redirect=0; state SHALL return to RUN; data fields are don't-care.
REQ-014 A bubble (out_valid=0) SHALL always have reg_write_q=mem_read_q=mem_write_q=0.
REQ-015 State machine SHALL have two states: RUN and SQUASH; reset state RUN.
REQ-016 RUN: a captured valid jr (in_valid=1, jr_control=1) SHALL set redirect=1 and redirect_pc=read_data1 on the next cycle and move to SQUASH.
REQ-017 RUN: a captured valid beq with ALU sub result zero SHALL set redirect=1, redirect_pc=pc_plus4+(imm<<2) (mod 2^32), and move to SQUASH; a not-taken beq SHALL cause neither.
REQ-018 jr and beq SHALL be captured with reg_write_q=0 and mem_*_q=0 regardless of the control inputs.
REQ-019 redirect SHALL be high for exactly one unstalled cycle per redirecting instruction and SHALL clear on the next capture edge.
REQ-020 SQUASH: the next captured in_valid=1 instruction SHALL be loaded as a bubble, then state SHALL return to RUN; captures with in_valid=0 SHALL leave the state in SQUASH.
REQ-021 SQUASH: a jr or beq arriving as the squashed instruction SHALL NOT redirect.
REQ-022 Simultaneous redirect condition and flush SHALL resolve as flush (no redirect, state RUN).

Reset
REQ-023 While rst_n=0 at a rising edge, all outputs SHALL become 0 and state SHALL become RUN, overriding stall and flush.
REQ-024 Reset asserted mid-redirect or in SQUASH SHALL cancel the pending redirect and any pending squash.

Verification
REQ-025 Add: A=32'h7FFFFFFF, B=1, alu_control=000, in_valid=1 -> next cycle alu_result=32'h80000000, zero=0, out_valid=1.
REQ-026 slt: A=32'hFFFFFFFF, B=0, code 100 -> alu_result=1; swap operands -> 0; sub of equal values -> zero=1.
REQ-027 jr: read_data1=32'h00400020, jr_control=1 -> redirect=1 for one cycle, redirect_pc=32'h00400020, reg_write_q=0; next valid instruction emerges with out_valid=0; the following one with out_valid=1.
REQ-028 beq taken: A=B=5, alu_control=001, pc_plus4=32'h100, imm=32'hFFFFFFFF -> redirect_pc=32'h0FC; same with A=5, B=6 -> no redirect.
REQ-029 Stall/flush: stall=1 for 3 cycles after jr capture -> redirect and outputs held constant; then flush=1 with stall=1 -> out_valid=0, redirect=0, squashing=0.
REQ-030 Reset in SQUASH: rst_n=0 for one edge -> all outputs 0, squashing=0; next valid add passes with out_valid=1.
